// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and transmitter-facing signals of the shared UART transmit arbiter.
// master is the arbiter side; slave is the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int GID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_done;
    logic                    grant_valid;
    logic [GID_W-1:0]        grant_id;
    logic                    timeout_err;

    modport master (
        input  req_valid, req_data, tx_done,
        output req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_done,
        input  req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// with a watchdog that reclaims the transmitter if frame completion never arrives.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int GID_W          = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [GID_W-1:0] GID_LAST = GID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [GID_W-1:0]   last_grant_r, last_grant_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
    logic [N_REQ-1:0]   req_ready_r, req_ready_s;
    logic               tx_start_r, tx_start_s;
    logic [DATA_W-1:0]  tx_data_r, tx_data_s;
    logic               grant_valid_r, grant_valid_s;
    logic [GID_W-1:0]   grant_id_r, grant_id_s;
    logic               timeout_err_r, timeout_err_s;
    logic [GID_W-1:0]   pick_s;
    logic [DATA_W-1:0]  req_byte_s [N_REQ];

    // First pending requester scanning upward from the one after the last grant, wrapping.
    function automatic logic [GID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                 input logic [GID_W-1:0] last);
        logic [GID_W-1:0] pick;
        logic [GID_W-1:0] cand;
        logic             found;
        pick  = {GID_W{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = GID_W'((int'(last) + k) % N_REQ);
            if (!found && valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_byte_s[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    assign pick_s    = rr_pick(bus.req_valid, last_grant_r);
    assign cnt_inc_s = (cnt_r >= CNT_SAT) ? cnt_r : cnt_r + CNT_W'(1);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s       = state_r;
        last_grant_s  = last_grant_r;
        cnt_s         = cnt_r;
        req_ready_s   = {N_REQ{1'b0}};
        tx_start_s    = 1'b0;
        tx_data_s     = tx_data_r;
        grant_valid_s = 1'b0;
        grant_id_s    = grant_id_r;
        timeout_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    state_s             = ST_START;
                    grant_id_s          = pick_s;
                    tx_data_s           = req_byte_s[pick_s];
                    cnt_s               = {CNT_W{1'b0}};
                    req_ready_s[pick_s] = 1'b1;
                    tx_start_s          = 1'b1;
                    grant_valid_s       = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_s       = ST_WAIT_DONE;
                cnt_s         = cnt_inc_s;
                grant_valid_s = 1'b1;
            end
            ST_WAIT_DONE: begin
                // A completion arriving on the expiry cycle beats the watchdog.
                if (bus.tx_done) begin
                    state_s      = ST_IDLE;
                    last_grant_s = grant_id_r;
                end else if (cnt_r == CNT_LAST) begin
                    state_s       = ST_IDLE;
                    last_grant_s  = grant_id_r;
                    timeout_err_s = 1'b1;
                end else begin
                    cnt_s         = cnt_inc_s;
                    grant_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= GID_LAST;
            cnt_r         <= {CNT_W{1'b0}};
            req_ready_r   <= {N_REQ{1'b0}};
            tx_start_r    <= 1'b0;
            tx_data_r     <= {DATA_W{1'b0}};
            grant_valid_r <= 1'b0;
            grant_id_r    <= {GID_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            last_grant_r  <= last_grant_s;
            cnt_r         <= cnt_s;
            req_ready_r   <= req_ready_s;
            tx_start_r    <= tx_start_s;
            tx_data_r     <= tx_data_s;
            grant_valid_r <= grant_valid_s;
            grant_id_r    <= grant_id_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.tx_start    = tx_start_r;
    assign bus.tx_data     = tx_data_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued as requests are
// presented and checked when tx_start appears; a transmitter model answers tx_done.
module tb_uart_tx_arbiter;
    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int GID_W   = 2;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .GID_W(GID_W)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT), .GID_W(GID_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp      = 0;
    int n_err      = 0;
    int cyc        = 0;
    int done_cnt   = -1;
    int done_delay = 10;
    int start_cyc  = 0;
    int start_gap  = 0;
    int n_starts   = 0;
    bit auto_done  = 1'b1;
    logic [N_REQ-1:0] keep = '0;
    logic [GID_W+DATA_W-1:0] sb_q [$];

    task automatic set_req(input int i, input logic [DATA_W-1:0] d, input bit k);
        bus.req_valid[i]                 = 1'b1;
        bus.req_data[i*DATA_W +: DATA_W] = d;
        keep[i]                          = k;
    endtask

    task automatic expect_grant(input logic [GID_W-1:0] id, input logic [DATA_W-1:0] d);
        sb_q.push_back({id, d});
    endtask

    // One clock: sample 1 ns after the edge, run the transmitter and requester models.
    task automatic tick();
        logic [GID_W+DATA_W-1:0] exp_v;
        @(posedge clk);
        #1;
        cyc++;
        bus.tx_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) bus.tx_done = 1'b1;
        end
        if (bus.tx_start === 1'b1) begin
            start_gap = cyc - start_cyc;
            start_cyc = cyc;
            n_starts++;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_start: got id=%0d data=%h, required no tx_start",
                         bus.grant_id, bus.tx_data);
            end else begin
                exp_v = sb_q.pop_front();
                if (bus.grant_id !== exp_v[DATA_W +: GID_W] || bus.tx_data !== exp_v[DATA_W-1:0] ||
                    bus.req_ready !== (4'b0001 << exp_v[DATA_W +: GID_W])) begin
                    n_err++;
                    $display("FAIL sb_grant: got id=%0d data=%h ready=%b, required id=%0d data=%h ready=%b",
                             bus.grant_id, bus.tx_data, bus.req_ready, exp_v[DATA_W +: GID_W],
                             exp_v[DATA_W-1:0], 4'b0001 << exp_v[DATA_W +: GID_W]);
                end
            end
            done_cnt = auto_done ? done_delay : -1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_ready[i] === 1'b1 && keep[i] == 1'b0) bus.req_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_start(input string name);
        int n0;
        int k;
        n0 = n_starts;
        k  = 0;
        while (n_starts == n0 && k < 100) begin
            tick();
            k++;
        end
        n_cmp++;
        if (n_starts == n0) begin
            n_err++;
            $display("FAIL %s_no_start: no tx_start within %0d cycles, required one", name, k);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.grant_valid !== 1'b0 || bus.req_valid != '0) && k < 300) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k >= 300) begin
            n_err++;
            $display("FAIL %s_idle_timeout: %0d grants still pending, required 0", name, sb_q.size());
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        keep          = '0;
        done_cnt      = -1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.req_ready, bus.tx_start, bus.tx_data, bus.grant_valid, bus.grant_id, bus.timeout_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b start=%b data=%h gv=%b id=%0d to=%b, required all 0",
                     bus.req_ready, bus.tx_start, bus.tx_data, bus.grant_valid, bus.grant_id, bus.timeout_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int k;
        expect_grant(2'd2, 8'hA5);
        set_req(2, 8'hA5, 1'b0);
        tick();
        n_cmp++;
        if (bus.tx_start !== 1'b1 || bus.req_ready !== 4'b0100 || bus.grant_id !== 2'd2) begin
            n_err++;
            $display("FAIL single_latency: got start=%b ready=%b id=%0d, required 1 0100 2",
                     bus.tx_start, bus.req_ready, bus.grant_id);
        end
        k = 0;
        while (bus.grant_valid === 1'b1 && k < 30) begin
            n_cmp++;
            if (bus.tx_data !== 8'hA5 || bus.grant_id !== 2'd2) begin
                n_err++;
                $display("FAIL single_hold: got data=%h id=%0d at +%0d, required a5 2", bus.tx_data, bus.grant_id, k);
            end
            tick();
            k++;
        end
        n_cmp++;
        if (k != 11) begin
            n_err++;
            $display("FAIL single_release: grant_valid fell %0d cycles after start, required 11", k);
        end
    endtask

    task automatic test_round_robin();
        int k;
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < 5; i++) expect_grant(2'(i % N_REQ), 8'h10 + 8'(i % N_REQ));
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        bus.req_valid = '0;
        keep          = '0;
        n_cmp++;
        if (sb_q.size() != 0 || start_gap != 12) begin
            n_err++;
            $display("FAIL rr_sequence: got %0d left, gap=%0d, required 0 left, gap=12", sb_q.size(), start_gap);
        end
        wait_idle("rr");
    endtask

    task automatic test_wrap();
        expect_grant(2'd3, 8'h33);
        set_req(3, 8'h33, 1'b0);
        wait_idle("wrap_first");
        expect_grant(2'd1, 8'h31);
        expect_grant(2'd3, 8'h3C);
        set_req(1, 8'h31, 1'b0);
        set_req(3, 8'h3C, 1'b0);
        wait_idle("wrap_pair");
    endtask

    // Watch timeout_err and grant_valid for 25 cycles after the START cycle.
    task automatic watch_after_start(input string name, input int exp_pulses);
        int s;
        int to_at;
        int to_cnt;
        int gv_at;
        s = start_cyc;
        to_at = -1;
        to_cnt = 0;
        gv_at = -1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (bus.timeout_err === 1'b1) begin
                to_cnt++;
                if (to_at < 0) to_at = cyc - s;
            end
            if (bus.grant_valid !== 1'b1 && gv_at < 0) gv_at = cyc - s;
        end
        n_cmp++;
        if (to_cnt != exp_pulses || (exp_pulses == 1 && to_at != 20)) begin
            n_err++;
            $display("FAIL %s_timeout_err: got %0d pulses at +%0d, required %0d at +20", name, to_cnt, to_at, exp_pulses);
        end
        n_cmp++;
        if (gv_at != 20) begin
            n_err++;
            $display("FAIL %s_grant_release: grant_valid fell at +%0d, required +20", name, gv_at);
        end
    endtask

    task automatic test_timeout();
        auto_done = 1'b0;
        expect_grant(2'd0, 8'h5A);
        set_req(0, 8'h5A, 1'b0);
        wait_start("timeout");
        watch_after_start("timeout", 1);
        auto_done = 1'b1;
        expect_grant(2'd2, 8'h2B);
        expect_grant(2'd0, 8'h0B);
        set_req(0, 8'h0B, 1'b0);
        set_req(2, 8'h2B, 1'b0);
        wait_idle("after_timeout");
    endtask

    task automatic test_done_race();
        done_delay = 19;
        expect_grant(2'd1, 8'h19);
        set_req(1, 8'h19, 1'b0);
        wait_start("race");
        watch_after_start("race", 0);
        done_delay = 10;
    endtask

    task automatic test_reset_mid();
        auto_done = 1'b0;
        expect_grant(2'd0, 8'hC3);
        set_req(0, 8'hC3, 1'b0);
        wait_start("rstmid");
        repeat (5) tick();
        rst = 1'b1;
        set_req(3, 8'hD4, 1'b0);
        tick();
        n_cmp++;
        if ({bus.req_ready, bus.tx_start, bus.tx_data, bus.grant_valid, bus.grant_id, bus.timeout_err} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got ready=%b start=%b data=%h gv=%b id=%0d to=%b, required all 0",
                     bus.req_ready, bus.tx_start, bus.tx_data, bus.grant_valid, bus.grant_id, bus.timeout_err);
        end
        done_cnt  = -1;
        auto_done = 1'b1;
        expect_grant(2'd3, 8'hD4);
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'd3) begin
            n_err++;
            $display("FAIL rstmid_regrant: got start=%b id=%0d, required 1 3", bus.tx_start, bus.grant_id);
        end
        wait_idle("rstmid");
        bus.tx_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (bus.grant_valid !== 1'b0 || bus.tx_start !== 1'b0 || bus.timeout_err !== 1'b0) begin
                n_err++;
                $display("FAIL stray_done: got gv=%b start=%b to=%b, required 0 0 0",
                         bus.grant_valid, bus.tx_start, bus.timeout_err);
            end
        end
        expect_grant(2'd1, 8'hE1);
        set_req(1, 8'hE1, 1'b0);
        tick();
        n_cmp++;
        if (bus.tx_start !== 1'b1) begin
            n_err++;
            $display("FAIL stray_then_grant: got start=%b, required 1", bus.tx_start);
        end
        wait_idle("stray");
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_done   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_done_race();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded 1 ms, required completion");
        $fatal(1, "bench did not finish");
    end
endmodule
